// File: rtl/sme_if.sv
// sme_if: character-stream host bus between a host and the string-matching engine.
interface sme_if #(
  parameter int CHAR_W = 8,
  parameter int IDX_W  = 5
);
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  modport master (output chardata, isstring, ispattern, input busy, valid, match, match_index);
  modport slave  (input chardata, isstring, ispattern, output busy, valid, match, match_index);
endinterface

// File: rtl/sme_param.sv
// sme_param: stores a string and a pattern (literals, '.', '^', '$', one '*') and reports the leftmost match.
module sme_param #(
  parameter int CHAR_W  = 8,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int IDX_W   = 5
) (
  input logic clk,
  input logic reset,
  sme_if.slave bus
);
  localparam int PW = $clog2(MAX_PAT);
  typedef logic [CHAR_W-1:0] ch_t;
  typedef logic [IDX_W:0] si_t;
  typedef logic [PW:0] pi_t;
  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH_PRE, SEARCH_SUF, DONE} state_t;
  localparam ch_t SP = ch_t'(8'h20);
  localparam ch_t DOT = ch_t'(8'h2E);
  localparam ch_t CARET = ch_t'(8'h5E);
  localparam ch_t DOLLAR = ch_t'(8'h24);
  localparam ch_t STAR = ch_t'(8'h2A);
  localparam si_t SMAX = si_t'(MAX_STR);
  localparam pi_t PMAX = pi_t'(MAX_PAT);
  state_t state, nxt;
  ch_t str [MAX_STR];
  ch_t pat [MAX_PAT];
  si_t str_len, off, pos;
  pi_t pat_len, star_pos, j, seg_start, seg_end;
  logic [IDX_W-1:0] mi, pm1;
  logic has_star, hit;
  logic idle_like, str_we, pat_we, str_first, pat_first, searching, suf, suf_more;
  logic fail, seg_done, in_str, zw, ok;
  ch_t pc, sc, pv;
  always_comb begin
    idle_like = state == IDLE || state == LOAD_STR || state == DONE;
    str_we = idle_like && bus.isstring;
    pat_we = bus.ispattern && (state == LOAD_PAT || (idle_like && !bus.isstring));
    str_first = str_we && state != LOAD_STR;
    pat_first = pat_we && state != LOAD_PAT;
    searching = state == SEARCH_PRE || state == SEARCH_SUF;
    suf = state == SEARCH_SUF;
    suf_more = has_star && (star_pos + 1'b1) < pat_len;
    seg_start = suf ? star_pos + 1'b1 : '0;
    seg_end = (suf || !has_star) ? pat_len : star_pos;
    fail = off > str_len;
    seg_done = j >= seg_end;
    pm1 = pos[IDX_W-1:0] - 1'b1;
    pc = pat[j[PW-1:0]];
    sc = str[pos[IDX_W-1:0]];
    pv = str[pm1];
    in_str = pos < str_len;
    // '^' and '$' consume no string character, so only the pattern pointer moves
    zw = pc == CARET || pc == DOLLAR;
    ok = pc == CARET ? (pos == '0 || pv == SP) :
         pc == DOLLAR ? (!in_str || sc == SP) :
         in_str && (pc == DOT || sc == pc);
    nxt = idle_like ? (bus.isstring ? LOAD_STR : bus.ispattern ? LOAD_PAT : IDLE) : state;
    if (state == LOAD_PAT) nxt = bus.ispattern ? LOAD_PAT : SEARCH_PRE;
    if (searching) nxt = (fail || (seg_done && (suf || !suf_more))) ? DONE : seg_done ? SEARCH_SUF : state;
  end
  always_ff @(posedge clk, posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk, posedge reset) begin
    if (reset) begin
      str_len <= '0;
      pat_len <= '0;
      star_pos <= '0;
      has_star <= 1'b0;
      off <= '0;
      pos <= '0;
      j <= '0;
      mi <= '0;
      hit <= 1'b0;
    end else begin
      if (str_first) str_len <= si_t'(1);
      else if (str_we && str_len < SMAX) str_len <= str_len + 1'b1;
      if (pat_first) begin
        pat_len <= pi_t'(1);
        has_star <= bus.chardata == STAR;
        star_pos <= '0;
      end else if (pat_we && pat_len < PMAX) begin
        pat_len <= pat_len + 1'b1;
        if (bus.chardata == STAR && !has_star) begin
          has_star <= 1'b1;
          star_pos <= pat_len;
        end
      end
      if (state == LOAD_PAT) begin
        off <= '0;
        pos <= '0;
        j <= '0;
        hit <= 1'b0;
      end else if (searching && !fail) begin
        if (seg_done) begin
          // prefix done: keep its start as the result, resume the suffix scan where the prefix ended
          if (!suf) begin
            mi <= off[IDX_W-1:0];
            off <= pos;
            j <= star_pos + 1'b1;
          end
          hit <= suf || !suf_more;
        end else if (ok) begin
          j <= j + 1'b1;
          if (!zw) pos <= pos + 1'b1;
        end else begin
          off <= off + 1'b1;
          pos <= off + 1'b1;
          j <= seg_start;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (str_first) str[0] <= bus.chardata;
    else if (str_we && str_len < SMAX) str[str_len[IDX_W-1:0]] <= bus.chardata;
    if (pat_first) pat[0] <= bus.chardata;
    else if (pat_we && pat_len < PMAX) pat[pat_len[PW-1:0]] <= bus.chardata;
  end
  assign bus.busy = searching;
  assign bus.valid = state == DONE;
  assign bus.match = state == DONE && hit;
  assign bus.match_index = (state == DONE && hit) ? mi : '0;
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: scoreboard bench for sme_param driven by directed string/pattern vectors.
module tb_sme_param;
  localparam int CW = 8, MS = 32, MP = 8, IW = 5;
  localparam int LAT = 2 * (MS + 1) * (MP + 1) + 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0, mismatched = 0, seen = 0;
  logic [IW:0] exp_q[$];
  logic [IW:0] e_r;
  logic last_v = 1'b0;
  sme_if #(.CHAR_W(CW), .IDX_W(IW)) bus();
  sme_param #(.CHAR_W(CW), .MAX_STR(MS), .MAX_PAT(MP), .IDX_W(IW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: got match=%0b idx=%0d want no result", bus.match, bus.match_index);
      end else begin
        e_r = exp_q.pop_front();
        if ({bus.busy, bus.match, bus.match_index} !== {1'b0, e_r}) begin
          mismatched++;
          $display("FAIL result: got busy=%0b match=%0b idx=%0d want busy=0 match=%0b idx=%0d",
                   bus.busy, bus.match, bus.match_index, e_r[IW], e_r[IW-1:0]);
        end
      end
      if (last_v) begin
        compared++;
        mismatched++;
        $display("FAIL valid_width: got valid high 2 cycles want 1");
      end
      seen++;
    end
    last_v <= bus.valid;
  end
  task automatic send(input string s, input bit p, input bit now = 1'b0);
    for (int k = 0; k < s.len(); k++) begin
      if (!(now && k == 0)) @(negedge clk);
      bus.chardata = s[k];
      bus.isstring = !p;
      bus.ispattern = p;
    end
    @(negedge clk);
    bus.isstring = 1'b0;
    bus.ispattern = 1'b0;
  endtask
  task automatic search(input string pat, input bit m, input int idx);
    int b;
    exp_q.push_back({m, IW'(idx)});
    send(pat, 1'b1);
    b = seen;
    for (int c = 0; c < LAT && seen == b; c++) @(negedge clk);
    if (seen == b) begin
      compared++;
      mismatched++;
      $display("FAIL timeout %s: got no valid want valid within %0d cycles", pat, LAT);
      exp_q.delete();
    end
  endtask
  task automatic search_then_load(input string pat, input bit m, input int idx, input string ns);
    int c;
    exp_q.push_back({m, IW'(idx)});
    send(pat, 1'b1);
    for (c = 0; c < LAT && !bus.valid; c++) @(negedge clk);
    if (!bus.valid) begin
      compared++;
      mismatched++;
      $display("FAIL timeout %s: got no valid want valid within %0d cycles", pat, LAT);
      exp_q.delete();
    end else send(ns, 1'b0, 1'b1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end
  initial begin
    string fill;
    fill = "abcdefghijklmnopqrstuvwabcdef";
    bus.chardata = '0;
    bus.isstring = 1'b0;
    bus.ispattern = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {bus.busy, bus.valid, bus.match, bus.match_index}, 0);
    reset = 1'b0;
    send("hello world", 1'b0);
    search("wor", 1'b1, 6);
    search("^wor", 1'b1, 6);
    search("^orl", 1'b0, 0);
    search("lo$", 1'b1, 3);
    search("ld$", 1'b1, 9);
    search("l*d$", 1'b1, 2);
    search("x*d", 1'b0, 0);
    search_then_load("*wo", 1'b1, 0, "aaab");
    search("a.b", 1'b1, 1);
    search("....", 1'b1, 0);
    search(".....", 1'b0, 0);
    send({fill, "xyz"}, 1'b0);
    search("xyz$", 1'b1, 29);
    send({fill, "xyzq"}, 1'b0);
    search("xyz$", 1'b1, 29);
    send("zzz", 1'b1);
    repeat (3) @(negedge clk);
    check("busy_mid_search", bus.busy, 1);
    #2 reset = 1'b1;
    #1 check("async_reset_out", {bus.busy, bus.valid, bus.match, bus.match_index}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send("hello world", 1'b0);
    search("o w", 1'b1, 4);
    search("^hello$", 1'b1, 0);
    repeat (3) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
